// File: rtl/mat_mul_pkg.sv
// Shared definitions for the mat_mul sequencer.
//   state_t : FSM encoding (IDLE=0, LOAD_A=1, LOAD_B=2, CALC=3, OUTPUT=4)
//   dim_of  : matrix dimension derived from DIM_LOG
package mat_mul_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CALC   = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    function automatic int dim_of(input int dim_log);
        return 1 << dim_log;
    endfunction

endpackage

// File: rtl/mat_mul_idx_cnt.sv
// Loop index counter used for the i/j/k loops of the multiply.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : advance by one this cycle
//   clr      : force to zero (takes priority over en)
//   cnt      : current index
//   wrap     : high in the cycle the counter rolls over from all-ones to zero
module mat_mul_idx_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == '1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mat_mul_ctrl.sv
// Sequencer for the mat_mul accelerator. Loads A or B from the slave stream,
// computes R = A*B through the external MAC, and streams R on the master port.
// Ports:
//   s00_axi_aclk / s00_axi_reset : clock, synchronous active-high reset
//   s00_axis_*                   : slave stream handshake (tvalid, tlast in; tready out)
//   m00_axis_*                   : master stream handshake (tready in; tvalid, tlast out)
//   sel, start                   : load target (0=A, 1=B), calculation launch (level)
//   en_x / rw_x / addr_x         : BRAM controls for A, B, R (rw 1 = write)
//   mac_clr, mac_en              : MAC accumulator load / operand valid
//   busy                         : high in any state but IDLE
//   load_err                     : sticky stream tlast mismatch (only with MAT_MUL_CTRL_TLAST_CHECK_EN)
//   state_dbg                    : current FSM state encoding
// Build option: define MAT_MUL_CTRL_TLAST_CHECK_EN to check s00_axis_tlast
// against the beat count and end a load early on tlast.
//
// Handshake rule for both streams: a beat transfers on a rising edge where
// tvalid and tready are both high; a source holds tvalid (and its data/tlast)
// until that transfer and never withdraws it, and ready may toggle freely.
module mat_mul_ctrl
    import mat_mul_pkg::*;
#(
    parameter int DIM_LOG = 1,
    localparam int SIZE_LOG = 2 * DIM_LOG
) (
    input  logic                s00_axi_aclk,
    input  logic                s00_axi_reset,
    input  logic                s00_axis_tvalid,
    input  logic                s00_axis_tlast,
    output logic                s00_axis_tready,
    input  logic                m00_axis_tready,
    output logic                m00_axis_tvalid,
    output logic                m00_axis_tlast,
    input  logic                sel,
    input  logic                start,
    output logic                en_A,
    output logic                en_B,
    output logic                en_R,
    output logic                rw_A,
    output logic                rw_B,
    output logic                rw_R,
    output logic [SIZE_LOG-1:0] addr_A,
    output logic [SIZE_LOG-1:0] addr_B,
    output logic [SIZE_LOG-1:0] addr_R,
    output logic                mac_clr,
    output logic                mac_en,
    output logic                busy,
`ifdef MAT_MUL_CTRL_TLAST_CHECK_EN
    output logic                load_err,
`endif
    output logic [2:0]          state_dbg
);

    localparam int DIM  = dim_of(DIM_LOG);
    localparam int SIZE = DIM * DIM;
    localparam logic [SIZE_LOG-1:0] PTR_LAST = SIZE_LOG'(SIZE - 1);

    logic clk, rst;
    assign clk = s00_axi_aclk;
    assign rst = s00_axi_reset;

    state_t               state, state_nx;
    logic [SIZE_LOG-1:0]  ptr, ptr_nx;
    logic                 rd_done, rd_done_nx;     // all CALC reads issued
    logic                 drain_cnt, drain_nx;     // counts the two drain cycles
    logic                 out_primed, out_primed_nx; // R[0] read issued in OUTPUT

    // Read pipeline: stage 1 aligns with BRAM data / mac_en, stage 2 with the
    // registered MAC result that is written to R.
    logic                 p1_valid, p1_k0, p1_klast;
    logic [SIZE_LOG-1:0]  p1_raddr;
    logic                 p2_wr;
    logic [SIZE_LOG-1:0]  p2_raddr;

    logic [DIM_LOG-1:0]   k_cnt, j_cnt, i_cnt;
    logic                 k_wrap, j_wrap, i_wrap;
    logic                 rd_en, cnt_clr;

    logic                 beat_ok, beat_last, load_end;

`ifdef MAT_MUL_CTRL_TLAST_CHECK_EN
    logic load_err_q, load_err_nx;
    assign load_err = load_err_q;
`else
    logic unused_tlast;
    assign unused_tlast = s00_axis_tlast;
`endif

    assign rd_en   = (state == S_CALC) && !rd_done;
    assign cnt_clr = (state != S_CALC);

    mat_mul_idx_cnt #(.W(DIM_LOG)) u_k_cnt (
        .clk (clk), .rst (rst), .en (rd_en),  .clr (cnt_clr), .cnt (k_cnt), .wrap (k_wrap)
    );
    mat_mul_idx_cnt #(.W(DIM_LOG)) u_j_cnt (
        .clk (clk), .rst (rst), .en (k_wrap), .clr (cnt_clr), .cnt (j_cnt), .wrap (j_wrap)
    );
    mat_mul_idx_cnt #(.W(DIM_LOG)) u_i_cnt (
        .clk (clk), .rst (rst), .en (j_wrap), .clr (cnt_clr), .cnt (i_cnt), .wrap (i_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            rd_done    <= 1'b0;
            drain_cnt  <= 1'b0;
            out_primed <= 1'b0;
            p1_valid   <= 1'b0;
            p1_k0      <= 1'b0;
            p1_klast   <= 1'b0;
            p1_raddr   <= '0;
            p2_wr      <= 1'b0;
            p2_raddr   <= '0;
`ifdef MAT_MUL_CTRL_TLAST_CHECK_EN
            load_err_q <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            rd_done    <= rd_done_nx;
            drain_cnt  <= drain_nx;
            out_primed <= out_primed_nx;
            p1_valid   <= rd_en;
            p1_k0      <= (k_cnt == '0);
            p1_klast   <= k_wrap;
            p1_raddr   <= {i_cnt, j_cnt};
            p2_wr      <= p1_valid && p1_klast;
            p2_raddr   <= p1_raddr;
`ifdef MAT_MUL_CTRL_TLAST_CHECK_EN
            load_err_q <= load_err_nx;
`endif
        end
    end

    always_comb begin
        state_nx        = state;
        ptr_nx          = ptr;
        rd_done_nx      = rd_done;
        drain_nx        = drain_cnt;
        out_primed_nx   = out_primed;
        s00_axis_tready = 1'b0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        en_A            = 1'b0;
        en_B            = 1'b0;
        en_R            = 1'b0;
        rw_A            = 1'b0;
        rw_B            = 1'b0;
        rw_R            = 1'b0;
        addr_A          = '0;
        addr_B          = '0;
        addr_R          = '0;
        mac_clr         = 1'b0;
        mac_en          = 1'b0;
        beat_ok         = 1'b0;
        beat_last       = (ptr == PTR_LAST);
        load_end        = beat_last;
`ifdef MAT_MUL_CTRL_TLAST_CHECK_EN
        load_err_nx     = load_err_q;
        load_end        = beat_last || s00_axis_tlast;
`endif

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_CALC;
                end else if (s00_axis_tvalid) begin
                    state_nx = sel ? S_LOAD_B : S_LOAD_A;
`ifdef MAT_MUL_CTRL_TLAST_CHECK_EN
                    load_err_nx = 1'b0;
`endif
                end
            end

            S_LOAD_A, S_LOAD_B: begin
                s00_axis_tready = 1'b1;
                beat_ok         = s00_axis_tvalid;
                if (beat_ok) begin
                    if (state == S_LOAD_A) begin
                        en_A   = 1'b1;
                        rw_A   = 1'b1;
                        addr_A = ptr;
                    end else begin
                        en_B   = 1'b1;
                        rw_B   = 1'b1;
                        addr_B = ptr;
                    end
`ifdef MAT_MUL_CTRL_TLAST_CHECK_EN
                    if (s00_axis_tlast != beat_last) begin
                        load_err_nx = 1'b1;
                    end
`endif
                    if (load_end) begin
                        ptr_nx   = '0;
                        state_nx = S_IDLE;
                    end else begin
                        ptr_nx = ptr + 1'b1;
                    end
                end
            end

            S_CALC: begin
                en_A    = rd_en;
                en_B    = rd_en;
                addr_A  = {i_cnt, k_cnt};
                addr_B  = {k_cnt, j_cnt};
                mac_en  = p1_valid;
                mac_clr = p1_valid && p1_k0;
                if (p2_wr) begin
                    en_R   = 1'b1;
                    rw_R   = 1'b1;
                    addr_R = p2_raddr;
                end
                if (i_wrap) begin
                    rd_done_nx = 1'b1;
                end
                if (rd_done) begin
                    drain_nx = 1'b1;
                    if (drain_cnt) begin
                        drain_nx   = 1'b0;
                        rd_done_nx = 1'b0;
                        state_nx   = S_OUTPUT;
                    end
                end
            end

            S_OUTPUT: begin
                if (!out_primed) begin
                    // Prefetch R[0] so the first beat is valid next cycle.
                    en_R          = 1'b1;
                    addr_R        = '0;
                    out_primed_nx = 1'b1;
                end else begin
                    m00_axis_tvalid = 1'b1;
                    m00_axis_tlast  = (ptr == PTR_LAST);
                    if (m00_axis_tready) begin
                        // Fetch the following element so data is ready with no bubble.
                        en_R   = 1'b1;
                        addr_R = ptr + 1'b1;
                        if (ptr == PTR_LAST) begin
                            ptr_nx        = '0;
                            out_primed_nx = 1'b0;
                            state_nx      = S_IDLE;
                        end else begin
                            ptr_nx = ptr + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mat_mul_ctrl.sv
// Self-checking bench for mat_mul_ctrl with behavioural 1-cycle BRAMs and MAC.
module tb_mat_mul_ctrl;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         s_tvalid = 0, s_tlast = 0, m_tready = 1, sel = 0, start = 0;
    logic [W-1:0] s_tdata = '0;
    logic         s_tready, m_tvalid, m_tlast;
    logic         en_A, en_B, en_R, rw_A, rw_B, rw_R, mac_clr, mac_en, busy;
    logic [1:0]   addr_A, addr_B, addr_R;
    logic [2:0]   state_dbg;
`ifdef MAT_MUL_CTRL_TLAST_CHECK_EN
    logic         load_err;
`endif

    mat_mul_ctrl #(.DIM_LOG(1)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_reset   (rst),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (s_tready),
        .m00_axis_tready (m_tready),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .sel             (sel),
        .start           (start),
        .en_A            (en_A),
        .en_B            (en_B),
        .en_R            (en_R),
        .rw_A            (rw_A),
        .rw_B            (rw_B),
        .rw_R            (rw_R),
        .addr_A          (addr_A),
        .addr_B          (addr_B),
        .addr_R          (addr_R),
        .mac_clr         (mac_clr),
        .mac_en          (mac_en),
        .busy            (busy),
`ifdef MAT_MUL_CTRL_TLAST_CHECK_EN
        .load_err        (load_err),
`endif
        .state_dbg       (state_dbg)
    );

    // ---------------- datapath models ----------------
    logic [W-1:0] mem_a [4];
    logic [W-1:0] mem_b [4];
    logic [W-1:0] mem_r [4];
    logic [W-1:0] dout_a = '0, dout_b = '0, dout_r = '0, acc = '0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = '0; mem_b[i] = '0; mem_r[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (en_A) begin
            if (rw_A) mem_a[addr_A] <= s_tdata; else dout_a <= mem_a[addr_A];
        end
        if (en_B) begin
            if (rw_B) mem_b[addr_B] <= s_tdata; else dout_b <= mem_b[addr_B];
        end
        if (en_R) begin
            if (rw_R) mem_r[addr_R] <= acc; else dout_r <= mem_r[addr_R];
        end
        if (mac_en) acc <= mac_clr ? W'(dout_a * dout_b) : W'(acc + dout_a * dout_b);
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int wr_a_cnt = 0, wr_b_cnt = 0, clr_cnt = 0, r_wr_cnt = 0;
    int beat_cnt = 0, cyc = 0, first_beat = 0, last_beat = 0;
    bit stream_on = 0;

    always @(posedge clk) begin
        logic [W-1:0] e;
        cyc++;
        if (en_A && rw_A) wr_a_cnt++;
        if (en_B && rw_B) wr_b_cnt++;
        if (mac_clr) clr_cnt++;
        if (en_R && rw_R) r_wr_cnt++;
        if (stream_on) check("tvalid_hold", m_tvalid, 1);
        if (!m_tvalid) check("tlast_no_valid", m_tlast, 0);
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", beat_cnt, 4);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", dout_r, e);
                check("beat_tlast", m_tlast, (exp_q.size() == 0));
            end
            if (beat_cnt == 0) first_beat = cyc;
            last_beat = cyc;
            beat_cnt++;
            stream_on = !m_tlast;
        end else if (m_tvalid) begin
            stream_on = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last);
        int n;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        n = 0;
        @(negedge clk);
        while (!s_tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("beat_wait_bound", (n < 20), 1);
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_calc(input bit bp, output int calc_cyc);
        int n;
        logic [3:0] pat;
        pat = 4'b1001;   // tready sequence 1,0,0,1 (bit index = cycle mod 4)
        start = 1'b1;
        tick();
        start = 1'b0;
        calc_cyc = 0;
        n = 0;
        while (state_dbg == 3'd3 && n < 50) begin
            tick();
            calc_cyc++;
            n++;
        end
        n = 0;
        while (state_dbg != 3'd0 && n < 100) begin
            m_tready = bp ? pat[n % 4] : 1'b1;
            tick();
            n++;
        end
        check("output_bound", (n < 100), 1);
        m_tready = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    int calc_cyc;

    initial begin
        repeat (3) tick();
        check("rst_state", state_dbg, 0);
        check("rst_busy", busy, 0);
        check("rst_outputs", {s_tready, m_tvalid, m_tlast, en_A, en_B, en_R, rw_A, rw_B,
                              rw_R, addr_A, addr_B, addr_R, mac_clr, mac_en}, 0);
        rst = 1'b0;
        tick();

`ifdef MAT_MUL_CTRL_TLAST_CHECK_EN
        sel = 1'b0;
        wr_a_cnt = 0;
        send_beat(16'd9, 1'b0);
        send_beat(16'd10, 1'b1);
        check("early_tlast_state", state_dbg, 0);
        check("early_tlast_err", load_err, 1);
        check("early_tlast_writes", wr_a_cnt, 2);
`endif

        // Load A with a 2-cycle stall before beat 3.
        sel = 1'b0;
        wr_a_cnt = 0;
        send_beat(16'd1, 1'b0);
        send_beat(16'd2, 1'b0);
        tick();
        tick();
        check("stall_writes", wr_a_cnt, 2);
        check("stall_state", state_dbg, 1);
        send_beat(16'd3, 1'b0);
        send_beat(16'd4, 1'b1);
        check("load_a_state", state_dbg, 0);
        check("load_a_writes", wr_a_cnt, 4);
        for (int i = 0; i < 4; i++) check("mem_a", mem_a[i], i + 1);
`ifdef MAT_MUL_CTRL_TLAST_CHECK_EN
        check("load_err_cleared", load_err, 0);
`endif

        // Load B.
        sel = 1'b1;
        wr_b_cnt = 0;
        for (int i = 0; i < 4; i++) send_beat(W'(i + 5), (i == 3));
        check("load_b_state", state_dbg, 0);
        check("load_b_writes", wr_b_cnt, 4);
        check("load_b_no_a", wr_a_cnt, 4);
        for (int i = 0; i < 4; i++) check("mem_b", mem_b[i], i + 5);
        sel = 1'b0;

        // Calculation + output with tready always high.
        clr_cnt = 0; r_wr_cnt = 0; beat_cnt = 0;
        exp_q.push_back(16'd19); exp_q.push_back(16'd22);
        exp_q.push_back(16'd43); exp_q.push_back(16'd50);
        run_calc(1'b0, calc_cyc);
        check("calc_cycles", calc_cyc, 10);
        check("mac_clr_count", clr_cnt, 4);
        check("r_writes", r_wr_cnt, 4);
        check("mem_r0", mem_r[0], 19);
        check("mem_r1", mem_r[1], 22);
        check("mem_r2", mem_r[2], 43);
        check("mem_r3", mem_r[3], 50);
        check("beats_full", beat_cnt, 4);
        check("beats_back_to_back", last_beat - first_beat, 3);
        check("queue_empty_full", exp_q.size(), 0);
        check("idle_after_out", busy, 0);

        // Output with backpressure.
        beat_cnt = 0;
        exp_q.push_back(16'd19); exp_q.push_back(16'd22);
        exp_q.push_back(16'd43); exp_q.push_back(16'd50);
        run_calc(1'b1, calc_cyc);
        check("bp_calc_cycles", calc_cyc, 10);
        check("beats_bp", beat_cnt, 4);
        check("queue_empty_bp", exp_q.size(), 0);

        // Reset in the middle of CALC.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("calc_entered", state_dbg, 3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_state", state_dbg, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_outputs", {en_A, en_B, en_R, mac_en, mac_clr, m_tvalid}, 0);
        rst = 1'b0;
        tick();
        check("post_rst_idle", state_dbg, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
